// File: rtl/tick_cap_bank.sv
// tick_cap_bank: a bank of N_CH tick counters with selectable sources, all captured
// together on a common strobe. A free-running time counter is timestamped on each
// PPS pulse into a small FIFO with a sticky overflow flag and a level interrupt.
// Every Wishbone access takes two cycles: a request cycle and then an ack cycle.
module tick_cap_bank #(
  parameter int N_CH       = 4,
  parameter int N_SRC      = 8,
  parameter int CW         = 16,
  parameter int TW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] tick_src,
  input  logic             cap_stb,
  input  logic             pps,
  output logic             irq,
  input  logic [7:0]       wb_addr,
  output logic [31:0]      wb_rdata,
  input  logic [31:0]      wb_wdata,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic             wb_ack
);

  localparam int SELW = $clog2(N_SRC);
  localparam int AW   = $clog2(FIFO_DEPTH);

  logic            r_ack;
  logic [4:0]      r_addr;
  logic            r_we;
  logic [31:0]     r_wdata;

  logic [CW-1:0]   r_cnt [N_CH];
  logic [CW-1:0]   r_cap [N_CH];
  logic [SELW-1:0] r_sel [N_CH];
  logic [N_CH-1:0] r_en;

  logic [TW-1:0]   r_time;
  logic [TW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            r_ovf;
  logic            r_irq_en;
  logic            r_irq;

  logic [AW:0]     w_level;
  logic            w_empty;
  logic            w_full;
  logic            w_wr;
  logic            w_rd;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_csr_wr;
  logic [N_CH-1:0] w_cfg_wr;
  logic [N_CH-1:0] w_tick;
  logic [31:0]     w_rdata;
  logic            w_unused;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_wr      = r_ack & r_we;
  assign w_rd      = r_ack & ~r_we;
  assign w_pop     = w_rd & (r_addr == 5'h02) & ~w_empty;
  assign w_push    = pps & (~w_full | w_pop);
  assign w_ovf_set = pps & w_full & ~w_pop;
  assign w_csr_wr  = w_wr & (r_addr == 5'h00);

  assign wb_ack    = r_ack;
  assign wb_rdata  = w_rdata;
  assign irq       = r_irq;
  assign w_unused  = ^{wb_addr[7:5], r_wdata};

  // Bus front end: ack every other cycle of a held cycle, latching the request on the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_ack <= wb_cyc & ~r_ack;
      if (wb_cyc & ~r_ack) begin
        r_addr  <= wb_addr[4:0];
        r_we    <= wb_we;
        r_wdata <= wb_wdata;
      end
    end
  end

  // Per-channel config write strobes and selected tick inputs (out-of-range selects never tick).
  always_comb begin
    w_cfg_wr = '0;
    w_tick   = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      w_cfg_wr[ch] = w_wr & (r_addr == 5'(24 + ch));
      if (r_sel[ch] <= SELW'(N_SRC - 1)) w_tick[ch] = tick_src[r_sel[ch]];
    end
  end

  // Channel counters: a config write clears the live count and beats a same-cycle tick;
  // captures take the pre-increment value so a coincident tick lands in the live counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        r_cnt[ch] <= '0;
        r_cap[ch] <= '0;
        r_sel[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (w_cfg_wr[ch]) begin
          r_cnt[ch] <= '0;
          r_en[ch]  <= r_wdata[31];
          r_sel[ch] <= r_wdata[SELW-1:0];
        end else if (r_en[ch] & w_tick[ch]) begin
          r_cnt[ch] <= r_cnt[ch] + 1'b1;
        end
        if (cap_stb) r_cap[ch] <= r_cnt[ch];
      end
    end
  end

  // Time counter, FIFO pointers, sticky overflow (set beats clear) and the registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_time <= r_time + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_csr_wr & r_wdata[2]) r_ovf <= 1'b0;
      if (w_csr_wr) r_irq_en <= r_wdata[0];
      r_irq <= r_irq_en & (~w_empty | r_ovf);
    end
  end

  // FIFO storage holds the time value seen in the cycle the PPS pulse arrives.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_time;
  end

  // Read mux, driven only during a read ack; the level field starts at bit 8.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (r_addr)
        5'h00: begin
          w_rdata[0]          = r_irq_en;
          w_rdata[1]          = ~w_empty;
          w_rdata[2]          = r_ovf;
          w_rdata[8 +: AW+1]  = w_level;
        end
        5'h01: w_rdata[TW-1:0] = r_time;
        5'h02: if (!w_empty) w_rdata[TW-1:0] = r_mem[r_rptr[AW-1:0]];
        default: begin
          for (int ch = 0; ch < N_CH; ch++) begin
            if (r_addr == 5'(16 + ch)) begin
              w_rdata[CW-1:0] = r_cap[ch];
            end else if (r_addr == 5'(24 + ch)) begin
              w_rdata[31]       = r_en[ch];
              w_rdata[SELW-1:0] = r_sel[ch];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_cap_bank.sv
// tb_tick_cap_bank: directed scenarios followed by randomized traffic, all checked
// against a queue/array reference model of the tick bank kept in this bench.
module tb_tick_cap_bank;

  localparam int N_CH       = 4;
  localparam int N_SRC      = 8;
  localparam int CW         = 16;
  localparam int TW         = 32;
  localparam int FIFO_DEPTH = 4;
  localparam longint CMASK   = (64'd1 << CW) - 1;
  localparam longint TMASK   = (64'd1 << TW) - 1;
  localparam int     SELMASK = (1 << $clog2(N_SRC)) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] tick_src;
  logic             cap_stb;
  logic             pps;
  logic             irq;
  logic [7:0]       wb_addr;
  logic [31:0]      wb_rdata;
  logic [31:0]      wb_wdata;
  logic             wb_we;
  logic             wb_cyc;
  logic             wb_ack;

  tick_cap_bank #(
    .N_CH(N_CH), .N_SRC(N_SRC), .CW(CW), .TW(TW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .tick_src(tick_src), .cap_stb(cap_stb), .pps(pps),
    .irq(irq), .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  longint mCnt [N_CH];
  longint mCap [N_CH];
  int     mSel [N_CH];
  bit     mEn  [N_CH];
  longint mTime;
  longint q[$];
  bit     mOvf, mIrqEn, mIrq;

  // Bus transaction being acked in the current cycle
  bit          bAck, bWe;
  logic [7:0]  bAddr;
  logic [31:0] bData;
  bit          rndOn, chkIrq;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int ch = 0; ch < N_CH; ch++) begin
      mCnt[ch] = 0; mCap[ch] = 0; mSel[ch] = 0; mEn[ch] = 0;
    end
    mTime = 0; q.delete(); mOvf = 0; mIrqEn = 0; mIrq = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present in that cycle
  function automatic void modelStep();
    longint oldCnt;
    bit pop, ovfSet, nextIrq;
    int a;
    a       = int'(bAddr[4:0]);
    ovfSet  = 0;
    nextIrq = mIrqEn && (q.size() > 0 || mOvf);
    pop     = bAck && !bWe && a == 2 && q.size() > 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      oldCnt = mCnt[ch];
      if (bAck && bWe && a == 24 + ch) begin
        mCnt[ch] = 0;
        mEn[ch]  = bData[31];
        mSel[ch] = int'(bData) & SELMASK;
      end else if (mEn[ch] && mSel[ch] < N_SRC && tick_src[mSel[ch]]) begin
        mCnt[ch] = (mCnt[ch] + 1) & CMASK;
      end
      if (cap_stb) mCap[ch] = oldCnt;
    end
    if (pop) void'(q.pop_front());
    if (pps) begin
      if (q.size() == FIFO_DEPTH) ovfSet = 1;
      else q.push_back(mTime);
    end
    if (bAck && bWe && a == 0) begin
      mIrqEn = bData[0];
      if (bData[2]) mOvf = 0;
    end
    if (ovfSet) mOvf = 1;
    mIrq  = nextIrq;
    mTime = (mTime + 1) & TMASK;
  endfunction

  function automatic logic [31:0] expRead(input logic [7:0] addr);
    int a;
    logic [31:0] v;
    a = int'(addr[4:0]);
    v = '0;
    if (a == 0)
      v = 32'(mIrqEn) | (32'(q.size() != 0) << 1) | (32'(mOvf) << 2) | (32'(q.size()) << 8);
    else if (a == 1)
      v = 32'(mTime);
    else if (a == 2)
      v = (q.size() > 0) ? 32'(q[0]) : 32'd0;
    else if (a >= 16 && a < 24 && a - 16 < N_CH)
      v = 32'(mCap[a-16]);
    else if (a >= 24 && a - 24 < N_CH)
      v = (32'(mEn[a-24]) << 31) | 32'(mSel[a-24]);
    return v;
  endfunction

  // One clock cycle: drive inputs, let the edge happen, update the model, sample at negedge
  task automatic step();
    if (rndOn) begin
      tick_src = N_SRC'($urandom);
      cap_stb  = ($urandom_range(0, 7) == 0);
      pps      = ($urandom_range(0, 5) == 0);
    end
    @(posedge clk);
    modelStep();
    @(negedge clk);
    tick_src = '0; cap_stb = 1'b0; pps = 1'b0;
    if (chkIrq) checkOutput("irq", irq, mIrq);
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input bit we, input logic [31:0] data,
                               input bit ppsOnAck, output logic [31:0] rd);
    wb_cyc = 1'b1; wb_addr = addr; wb_we = we; wb_wdata = data;
    step();
    checkOutput("ack_rise", wb_ack, 1);
    rd = wb_rdata;
    if (!we) checkOutput($sformatf("rd_%02h", addr), wb_rdata, expRead(addr));
    wb_cyc = 1'b0;
    bAck = 1; bWe = we; bAddr = addr; bData = data;
    if (ppsOnAck) pps = 1'b1;
    step();
    bAck = 0;
    checkOutput("ack_fall", wb_ack, 0);
    checkOutput("rdata_idle", wb_rdata, 0);
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(addr, 1'b1, data, 1'b0, dummy);
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [31:0] rd);
    applyStimulus(addr, 1'b0, 32'd0, 1'b0, rd);
  endtask

  // Directed scenarios, random traffic, then reset in the middle of a FIFO read
  initial begin
    logic [31:0] rd;
    longint ts [5];
    tick_src = '0; cap_stb = 0; pps = 0;
    wb_addr = '0; wb_wdata = '0; wb_we = 0; wb_cyc = 0;
    bAck = 0; bWe = 0; bAddr = '0; bData = '0; rndOn = 0; chkIrq = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", wb_ack, 0);
    checkOutput("reset_rdata", wb_rdata, 0);
    checkOutput("reset_irq", irq, 0);
    modelReset();
    rst = 1'b0;
    chkIrq = 1;

    busRead(8'h00, rd); checkOutput("reset_csr", rd, 0);
    busRead(8'h18, rd); checkOutput("reset_cfg0", rd, 0);

    // Source select: only tick_src[3] counts for ch0
    busWrite(8'h18, 32'h8000_0003);
    repeat (5) begin tick_src[3] = 1'b1; step(); end
    repeat (2) begin tick_src[2] = 1'b1; step(); end
    cap_stb = 1'b1; step();
    busRead(8'h10, rd); checkOutput("plan_cap0", rd, 5);
    busRead(8'h11, rd); checkOutput("plan_cap1_off", rd, 0);
    busRead(8'h18, rd); checkOutput("plan_cfg0", rd, 32'h8000_0003);

    // Tick coincident with capture
    busWrite(8'h18, 32'h8000_0003);
    repeat (7) begin tick_src[3] = 1'b1; step(); end
    tick_src[3] = 1'b1; cap_stb = 1'b1; step();
    busRead(8'h10, rd); checkOutput("coinc_cap7", rd, 7);
    cap_stb = 1'b1; step();
    busRead(8'h10, rd); checkOutput("coinc_cap8", rd, 8);

    // FIFO fill, overflow and drain
    busWrite(8'h00, 32'h1);
    for (int k = 0; k < 4; k++) begin
      repeat (k + 2) step();
      ts[k] = mTime; pps = 1'b1; step();
    end
    pps = 1'b1; step();
    step();
    busRead(8'h00, rd); checkOutput("ovf_csr", rd, 32'h407);
    checkOutput("ovf_irq", irq, 1);
    for (int k = 0; k < 4; k++) begin
      busRead(8'h02, rd); checkOutput($sformatf("ts%0d", k), rd, ts[k]);
    end
    busRead(8'h02, rd); checkOutput("empty_pop", rd, 0);
    busWrite(8'h00, 32'h5);
    busRead(8'h00, rd); checkOutput("w1c_csr", rd, 32'h1);
    checkOutput("w1c_irq", irq, 0);

    // PPS coincident with a head pop while full
    for (int k = 0; k < 4; k++) begin
      repeat (3) step();
      ts[k] = mTime; pps = 1'b1; step();
    end
    applyStimulus(8'h02, 1'b0, 32'd0, 1'b1, rd);
    checkOutput("coinc_head", rd, ts[0]);
    ts[4] = (mTime - 1) & TMASK;
    busRead(8'h00, rd); checkOutput("coinc_csr", rd, 32'h403);
    for (int k = 1; k < 5; k++) begin
      busRead(8'h02, rd); checkOutput($sformatf("coinc_ts%0d", k), rd, ts[k]);
    end

    // Counter wrap at 2^CW
    chkIrq = 0;
    busWrite(8'h18, 32'h8000_0003);
    repeat (65537) begin tick_src[3] = 1'b1; step(); end
    cap_stb = 1'b1; step();
    chkIrq = 1;
    busRead(8'h10, rd); checkOutput("wrap_cap", rd, 1);

    // Randomized traffic
    rndOn = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: busWrite(8'(8'h18 + $urandom_range(0, 7)),
                    {1'($urandom_range(0, 1)), 23'd0, 8'($urandom)});
        1: busWrite(8'h00, 32'($urandom_range(0, 7)));
        2: busRead(8'($urandom), rd);
        3: busRead(8'h02, rd);
        4: busRead(8'(8'h10 + $urandom_range(0, 7)), rd);
        5: repeat ($urandom_range(1, 4)) step();
        default: busWrite(8'($urandom), $urandom);
      endcase
    end
    rndOn = 0;

    // Reset during an active FIFO read
    pps = 1'b1; step(); step();
    wb_cyc = 1'b1; wb_addr = 8'h02; wb_we = 1'b0;
    step();
    checkOutput("rst_pre_ack", wb_ack, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_ack", wb_ack, 0);
    checkOutput("rst_rdata", wb_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_irq", irq, 0);
    modelReset();
    wb_cyc = 1'b0;
    rst = 1'b0;
    busRead(8'h01, rd); checkOutput("rst_time", rd, 1);
    busRead(8'h00, rd); checkOutput("rst_csr", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
